mc_chroma_ref_buf: RTL and testbench
====================================

# mc_chroma_ref_buf

Chroma reference-window buffer on the responder side of the MC chroma reference-fetch interface. It is loaded with the U and V reference windows for one LCU from the external fetch path. It then answers pixel read requests (sign-extended x/y index plus U/V select) with 8 horizontally consecutive pixels, two cycles after each request. Out-of-window pixels are served by edge replication, so the MC chroma engine never sees an invalid address.

## Interface
- PIXEL_WIDTH, `PIXEL_WIDTH (8): bits per chroma sample.
- WIN_W, 96: window width in pixels; multiple of 8, at most 128.
- WIN_H, 96: window height in rows; at most 128.
- clk  input  1  single clock; all logic on its rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- load_start_i  input  1  one-cycle pulse; starts or restarts a window load.
- load_valid_i  input  1  load beat valid; always accepted while in LOAD.
- load_data_i  input  8*PIXEL_WIDTH  8 pixels per beat; pixel at lowest column in the MSBs.
- load_done_o  output  1  one-cycle pulse on the cycle the last beat is accepted.
- buf_ready_o  output  1  high while the window is valid (READY state).
- ref_rden_i  input  1  read request.
- ref_idx_x_i  input  8  first column of the request, two's complement.
- ref_idx_y_i  input  8  row of the request, two's complement.
- ref_sel_i  input  1  0 = U, 1 = V.
- ref_pel_o  output  8*PIXEL_WIDTH  pixels p0..p7; p0 (column x) in the MSBs.

## Operation
- Storage: per component, WIN_H rows × WIN_W/8 words of 64 bits.
  - Words are split into even and odd banks (word index LSB), so words k and k+1 can be read in the same cycle.
  - Banks are synchronous single-port arrays with 1-cycle read latency.
- FSM states: IDLE, LOAD, READY. Reset enters IDLE.
  - Any state: load_start_i → LOAD. The beat counter clears, and a restart during LOAD discards the beats already received.
  - LOAD: the beat counter increments on each load_valid_i.
  - LOAD → READY after the last beat, number 2*WIN_H*WIN_W/8 − 1 (2303 at default sizes).
  - READY: holds until the next load_start_i.
  - load_start_i takes priority over a coincident load_valid_i; that beat is dropped.
- Load order: U rows 0..WIN_H−1, then V rows 0..WIN_H−1. Within a row, words 0..WIN_W/8−1.
  - Beat address: sel = beat / (WIN_H*WIN_W/8); row and word follow in raster order.
- buf_ready_o = (state == READY).
- Reads:
  - ref_rden_i is honoured only in READY. Requests in IDLE or LOAD are ignored, ref_pel_o holds its value, and no bank is read.
  - Row clamp: yc = clamp(y, 0, WIN_H−1).
  - Per-pixel column clamp: cj = clamp(x+j, 0, WIN_W−1) for j = 0..7, with x+j evaluated in 9-bit signed arithmetic.
  - All cj lie in words floor(cx0/8) and floor(cx0/8)+1, where cx0 = clamp(x). Both words are read from the even/odd banks; a word index ≥ WIN_W/8 is not read and is not needed.
  - Output pixel j = window[sel][yc][cj].

## Timing
- Read latency is 2 cycles. A request sampled at edge N:
  - Bank read addresses are issued at edge N.
  - The realign/clamp result is registered into ref_pel_o at edge N+2.
- ref_pel_o holds between responses.
- Reads are fully pipelined, one request per cycle, no bubbles. Back-to-back requests produce back-to-back outputs.
- load_done_o is asserted in the same cycle as the last load_valid_i. buf_ready_o rises at the next edge.
- A read accepted in READY completes normally even if load_start_i arrives one cycle later; the pipeline drains. Bank writes start no earlier than the first beat after entering LOAD.
- Reset values: ref_pel_o = 0, load_done_o = 0, buf_ready_o = 0, state IDLE, beat counter 0, read pipeline valid bits 0.
- Reset mid-load or mid-read drops everything in flight. Array contents are not cleared, but buf_ready_o stays 0 until a complete load.

## Test plan
- Full load where pixel(sel,r,c) = (c + 3r + 64·sel) mod 256 → load_done_o pulses exactly on beat 2303 and buf_ready_o is 1 next cycle. Read (sel=0, x=16, y=10) → at N+2 ref_pel_o = 46,47,…,53 (p0 in MSB).
- Unaligned and back-to-back reads: V, y=0, x=5,6,7,8 on consecutive cycles → four consecutive outputs starting N+2, first = 69..76, last = 72..79.
- Left/top clamp: U, x=−3 (8'hFD), y=−5 → pixels 0,0,0,0,1,2,3,4.
- Right/bottom clamp: U, x=92, y=120 → row 95 → values (c+285) mod 256 for c = 92,93,94,95,95,95,95,95, i.e. 121,122,123,124,124,124,124,124.
- Read during LOAD and reload: assert ref_rden_i in LOAD → ref_pel_o unchanged. Reload with a pattern offset by 1 → same read as scenario 1 returns 47..54.
- Reset mid-load: rstn low at beat 1000, then a full load → no load_done_o until beat 2303 of the new load. buf_ready_o = 0 throughout and ref_pel_o = 0 after reset.

Source files
------------

// File: rtl/mc_chroma_ref_buf.sv
// mc_chroma_ref_buf
// Chroma reference-window buffer for the MC chroma engine. It is loaded with
// the U and V windows of one LCU, then answers 8-pixel row reads two cycles
// after each request. Out-of-window coordinates are edge-replicated.
//
// Ports:
//   clk, rstn        clock, async active-low reset
//   load_start_i     pulse: (re)start a window load
//   load_valid_i     load beat valid (8 pixels, lowest column in MSBs)
//   load_data_i      load beat data
//   load_done_o      pulse on the cycle the last beat is accepted
//   buf_ready_o      window valid, reads honoured
//   ref_rden_i       read request
//   ref_idx_x_i      first column, two's complement
//   ref_idx_y_i      row, two's complement
//   ref_sel_i        0 = U, 1 = V
//   ref_pel_o        p0..p7, p0 in the MSBs

// Synchronous single-port bank, one-cycle read latency.
module mc_chroma_ref_bank #(
  parameter int DW    = 64,
  parameter int DEPTH = 1152,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rdata     <= mem[addr];
  end
endmodule

// One output lane: picks a pixel out of the 16-pixel word pair
// (pixel 0 of the pair sits in the MSBs).
module mc_chroma_pel_sel #(
  parameter int PW = 8
) (
  input  logic [16*PW-1:0] pair,
  input  logic [3:0]       off,
  output logic [PW-1:0]    pel
);
  logic [3:0] idx;
  assign idx = 4'd15 - off;
  assign pel = pair[idx*PW +: PW];
endmodule

module mc_chroma_ref_buf #(
  parameter int PIXEL_WIDTH = 8,
  parameter int WIN_W       = 96,
  parameter int WIN_H       = 96
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic [8*PIXEL_WIDTH-1:0] load_data_i,
  output logic                     load_done_o,
  output logic                     buf_ready_o,
  input  logic                     ref_rden_i,
  input  logic [7:0]               ref_idx_x_i,
  input  logic [7:0]               ref_idx_y_i,
  input  logic                     ref_sel_i,
  output logic [8*PIXEL_WIDTH-1:0] ref_pel_o
);
  localparam int DW     = 8*PIXEL_WIDTH;
  localparam int WPR    = WIN_W/8;            // words per row
  localparam int HALF   = (WPR+1)/2;          // words per row per bank
  localparam int DEPTH  = 2*WIN_H*HALF;
  localparam int AW     = $clog2(DEPTH);
  localparam int NB     = 2*WIN_H*WPR;        // beats per full load
  localparam int BW     = $clog2(NB);
  localparam int STAGES = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]    state;
  logic [BW-1:0] beat_cnt;
  logic [4:0]    wr_word;
  logic [7:0]    wr_row;
  logic          wr_sel;
  logic          accept, last;

  // A coincident start wins, so that beat is dropped.
  assign accept      = (state == S_LOAD) && load_valid_i && !load_start_i;
  assign last        = (beat_cnt == BW'(NB-1));
  assign load_done_o = accept && last;
  assign buf_ready_o = (state == S_READY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      wr_word  <= '0;
      wr_row   <= '0;
      wr_sel   <= 1'b0;
    end else if (load_start_i) begin
      state    <= S_LOAD;
      beat_cnt <= '0;
      wr_word  <= '0;
      wr_row   <= '0;
      wr_sel   <= 1'b0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (last) state <= S_READY;
      // raster walk: word, then row, then component
      if (wr_word == 5'(WPR-1)) begin
        wr_word <= '0;
        if (wr_row == 8'(WIN_H-1)) begin
          wr_row <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end else begin
        wr_word <= wr_word + 1'b1;
      end
    end
  end

  // ---------------- read address generation ----------------
  logic                rd_go, rd_swap, ev_re, od_re;
  logic [AW-1:0]       ev_ra, od_ra, wa;
  logic [7:0][3:0]     rd_off;   // element 7 = offset for p0

  assign rd_go = ref_rden_i && (state == S_READY);

  always_comb begin
    int xi, yi, yc, cx0, k, cj, base;
    xi  = int'($signed(ref_idx_x_i));
    yi  = int'($signed(ref_idx_y_i));
    yc  = (yi < 0) ? 0 : ((yi > WIN_H-1) ? WIN_H-1 : yi);
    cx0 = (xi < 0) ? 0 : ((xi > WIN_W-1) ? WIN_W-1 : xi);
    k   = cx0 / 8;
    cj  = 0;
    rd_off = '0;
    // Every clamped column lies in words k and k+1, so a 4-bit offset
    // into the pair locates it.
    for (int j = 0; j < 8; j++) begin
      cj = xi + j;
      cj = (cj < 0) ? 0 : ((cj > WIN_W-1) ? WIN_W-1 : cj);
      rd_off[7-j] = 4'(cj - 8*k);
    end
    base    = (int'(ref_sel_i)*WIN_H + yc)*HALF;
    rd_swap = (k % 2) != 0;       // word k lives in the odd bank
    ev_ra   = AW'(base + (k+1)/2);
    od_ra   = AW'(base + k/2);
    // word k+1 past the row end is never needed, so leave that bank idle
    ev_re   = rd_go && (!rd_swap || (k+1 < WPR));
    od_re   = rd_go && ( rd_swap || (k+1 < WPR));
    wa      = AW'((int'(wr_sel)*WIN_H + int'(wr_row))*HALF + int'(wr_word)/2);
  end

  logic [DW-1:0] ev_rd, od_rd;

  mc_chroma_ref_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank_ev (
    .clk(clk), .we(accept && !wr_word[0]), .re(ev_re),
    .addr((accept && !wr_word[0]) ? wa : ev_ra),
    .wdata(load_data_i), .rdata(ev_rd)
  );

  mc_chroma_ref_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank_od (
    .clk(clk), .we(accept && wr_word[0]), .re(od_re),
    .addr((accept && wr_word[0]) ? wa : od_ra),
    .wdata(load_data_i), .rdata(od_rd)
  );

  // ---------------- read pipeline ----------------
  logic [STAGES:0]  vld_pipe;
  logic [7:0][3:0]  s1_off, s2_off;
  logic             s1_swap;
  logic [DW-1:0]    s2_lo, s2_hi;
  logic [7:0][PIXEL_WIDTH-1:0] lane_pel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe  <= '0;
      s1_off    <= '0;
      s1_swap   <= 1'b0;
      s2_off    <= '0;
      s2_lo     <= '0;
      s2_hi     <= '0;
      ref_pel_o <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_go};
      if (rd_go) begin
        s1_off  <= rd_off;
        s1_swap <= rd_swap;
      end
      if (vld_pipe[0]) begin
        s2_off <= s1_off;
        s2_lo  <= s1_swap ? od_rd : ev_rd;
        s2_hi  <= s1_swap ? ev_rd : od_rd;
      end
      if (vld_pipe[STAGES]) ref_pel_o <= lane_pel;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    mc_chroma_pel_sel #(.PW(PIXEL_WIDTH)) u_lane (
      .pair({s2_lo, s2_hi}),
      .off (s2_off[i]),
      .pel (lane_pel[i])
    );
  end

endmodule

// File: tb/tb_mc_chroma_ref_buf.sv
// Directed bench for mc_chroma_ref_buf at default sizes (96x96, 8-bit).
module tb_mc_chroma_ref_buf;
  localparam int WPR = 12;
  localparam int NB  = 2*96*WPR;   // 2304

  logic        clk, rstn;
  logic        load_start_i, load_valid_i, load_done_o, buf_ready_o;
  logic [63:0] load_data_i, ref_pel_o;
  logic        ref_rden_i, ref_sel_i;
  logic [7:0]  ref_idx_x_i, ref_idx_y_i;

  int n_tests = 0;
  int n_fail  = 0;

  mc_chroma_ref_buf dut (
    .clk(clk), .rstn(rstn),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .load_done_o(load_done_o),
    .buf_ready_o(buf_ready_o), .ref_rden_i(ref_rden_i),
    .ref_idx_x_i(ref_idx_x_i), .ref_idx_y_i(ref_idx_y_i),
    .ref_sel_i(ref_sel_i), .ref_pel_o(ref_pel_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d tests, required completion", n_tests);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pixel(sel,r,c) = (c + 3r + 64*sel + off) mod 256, lowest column in MSBs
  function automatic logic [63:0] beat_data(input int b, input int off);
    int sel, rem, row, word, c;
    logic [63:0] d;
    sel  = b / (96*WPR);
    rem  = b % (96*WPR);
    row  = rem / WPR;
    word = rem % WPR;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      c = word*8 + i;
      d[63-8*i -: 8] = 8'((c + 3*row + 64*sel + off) % 256);
    end
    return d;
  endfunction

  // Full load; abort_at >= 0 pulls reset at that beat instead.
  task automatic do_load(input string tag, input int off, input int abort_at,
                         input bit rd_during);
    int ndone, done_beat;
    bit rdy_bad;
    ndone = 0; done_beat = -1; rdy_bad = 1'b0;
    // coincident start + valid: this beat must be dropped
    load_start_i = 1'b1;
    load_valid_i = 1'b1;
    load_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    load_start_i = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == abort_at) begin
        load_valid_i = 1'b0;
        rstn = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, 64'(buf_ready_o), 64'd0);
        chk({tag, "_rst_pel"},   ref_pel_o,        64'd0);
        chk({tag, "_rst_ndone"}, 64'(ndone),       64'd0);
        tick();
        rstn = 1'b1;
        tick();
        return;
      end
      load_valid_i = 1'b1;
      load_data_i  = beat_data(b, off);
      ref_rden_i   = rd_during;
      ref_sel_i    = 1'b0;
      ref_idx_x_i  = 8'd0;
      ref_idx_y_i  = 8'd0;
      #2;
      if (load_done_o) begin ndone++; done_beat = b; end
      if (buf_ready_o) rdy_bad = 1'b1;
      tick();
    end
    load_valid_i = 1'b0;
    ref_rden_i   = 1'b0;
    chk({tag, "_ndone"},     64'(ndone),       64'd1);
    chk({tag, "_done_beat"}, 64'(done_beat),   64'(NB-1));
    chk({tag, "_rdy_load"},  64'(rdy_bad),     64'd0);
    chk({tag, "_rdy_after"}, 64'(buf_ready_o), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input bit sel, input logic [7:0] x,
                        input logic [7:0] y, input logic [63:0] exp);
    ref_rden_i  = 1'b1;
    ref_sel_i   = sel;
    ref_idx_x_i = x;
    ref_idx_y_i = y;
    tick();           // edge N
    ref_rden_i = 1'b0;
    tick();           // N+1
    tick();           // N+2
    chk(tag, ref_pel_o, exp);
  endtask

  logic [7:0]  b2b_x   [4];
  logic [63:0] b2b_exp [4];

  initial begin
    rstn = 1'b0;
    load_start_i = 1'b0; load_valid_i = 1'b0; load_data_i = '0;
    ref_rden_i = 1'b0; ref_sel_i = 1'b0; ref_idx_x_i = '0; ref_idx_y_i = '0;
    tick(); tick();
    chk("rst_pel",   ref_pel_o,        64'd0);
    chk("rst_ready", 64'(buf_ready_o), 64'd0);
    chk("rst_done",  64'(load_done_o), 64'd0);
    rstn = 1'b1;
    tick();

    // read in IDLE is ignored
    rd_chk("idle_rd", 1'b0, 8'd16, 8'd10, 64'd0);

    do_load("load1", 0, -1, 1'b0);
    rd_chk("u_x16_y10",   1'b0, 8'd16,  8'd10,  64'h2E2F_3031_3233_3435);
    rd_chk("v_x16_y10",   1'b1, 8'd16,  8'd10,  64'h6E6F_7071_7273_7475);
    rd_chk("clamp_lt",    1'b0, 8'hFD,  8'hFB,  64'h0000_0000_0102_0304);
    rd_chk("clamp_rb",    1'b0, 8'd92,  8'd120, 64'h797A_7B7C_7C7C_7C7C);
    rd_chk("even_pair",   1'b0, 8'd84,  8'd0,   64'h5455_5657_5859_5A5B);
    rd_chk("last_word",   1'b0, 8'd88,  8'd0,   64'h5859_5A5B_5C5D_5E5F);
    rd_chk("x_max_pos",   1'b0, 8'h7F,  8'd0,   64'h5F5F_5F5F_5F5F_5F5F);
    rd_chk("x_max_neg",   1'b1, 8'h80,  8'd0,   64'h4040_4040_4040_4040);

    // back-to-back unaligned V reads
    b2b_x   = '{8'd5, 8'd6, 8'd7, 8'd8};
    b2b_exp = '{64'h4546_4748_494A_4B4C, 64'h4647_4849_4A4B_4C4D,
                64'h4748_494A_4B4C_4D4E, 64'h4849_4A4B_4C4D_4E4F};
    for (int i = 0; i < 6; i++) begin
      ref_rden_i  = (i < 4);
      ref_sel_i   = 1'b1;
      ref_idx_y_i = 8'd0;
      ref_idx_x_i = b2b_x[i % 4];
      tick();
      if (i >= 2) chk($sformatf("b2b_%0d", i-2), ref_pel_o, b2b_exp[i-2]);
    end
    ref_rden_i = 1'b0;

    // read accepted in READY then reload one cycle later: the read drains
    // with old data, and reads during LOAD leave the output alone
    ref_rden_i = 1'b1; ref_sel_i = 1'b0; ref_idx_x_i = 8'd16; ref_idx_y_i = 8'd10;
    tick();
    ref_rden_i = 1'b0;
    do_load("reload", 1, -1, 1'b1);
    chk("drain_hold", ref_pel_o, 64'h2E2F_3031_3233_3435);
    rd_chk("reload_rd", 1'b0, 8'd16, 8'd10, 64'h2F30_3132_3334_3536);

    // reset mid-load, then a clean load
    do_load("abort", 0, 1000, 1'b0);
    chk("abort_ready", 64'(buf_ready_o), 64'd0);
    do_load("load3", 0, -1, 1'b0);
    rd_chk("load3_rd", 1'b0, 8'd16, 8'd10, 64'h2E2F_3031_3233_3435);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
